slatch_rdbk: RTL

- Read-back port for a bank of settable-latch control registers in TOM.
- The latch bank is the write side of the CPU register interface: it captures bus data on a write enable. This block is the read side. It snapshots a selected register, inserts programmable wait states, then drives the value for one acknowledged cycle.
- Supports coherent 32-bit reads of register pairs. The odd partner is frozen at the moment the even half is read.

---
 rtl/tom_rdbk_pkg.sv | 15 +
 rtl/slatch_rdbk_if.sv | 27 ++
 rtl/slatch_rdbk_sel.sv | 22 ++
 rtl/slatch_rdbk.sv | 119 +++++++++++
 4 files changed

// File: rtl/tom_rdbk_pkg.sv
// Shared types and default sizes for the latch-bank read-back port.
package tom_rdbk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAITST = 2'd1,
    DRIVE  = 2'd2
  } state_t;

  localparam int NREG_DEF = 16;
  localparam int AW_DEF   = 4;
  localparam int DW_DEF   = 16;
  localparam int CNT_W    = 3;

endpackage

// File: rtl/slatch_rdbk_if.sv
// Read-request / read-data bundle between the CPU bus side and the read-back port.
interface slatch_rdbk_if
  import tom_rdbk_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
);
  logic                 rd_req;
  logic [AW-1:0]        rd_addr;
  logic                 rd_pair;
  logic [NREG*DW-1:0]   regs_flat;
  logic [DW-1:0]        dout;
  logic                 dout_oe;
  logic                 rd_ack;
  logic                 busy;

  modport master (
    output rd_req, rd_addr, rd_pair, regs_flat,
    input  dout, dout_oe, rd_ack, busy
  );

  modport slave (
    input  rd_req, rd_addr, rd_pair, regs_flat,
    output dout, dout_oe, rd_ack, busy
  );
endinterface

// File: rtl/slatch_rdbk_sel.sv
// Combinational NREG:1 register selector; indices at or beyond NREG read as zero.
module slatch_rdbk_sel
  import tom_rdbk_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int DW   = DW_DEF,
  parameter int SW   = AW_DEF + 1
) (
  input  logic [NREG*DW-1:0] regs_flat,
  input  logic [SW-1:0]      sel,
  output logic [DW-1:0]      data
);

  // Pick the addressed register, defaulting to zero when nothing matches.
  always_comb begin
    data = '0;
    for (int i = 0; i < NREG; i++) begin
      if (int'(sel) == i) data = regs_flat[i*DW +: DW];
    end
  end

endmodule

// File: rtl/slatch_rdbk.sv
// Read-back port: snapshot a latch register, wait WAIT cycles, drive it for one acked cycle.
// Even/odd register pairs can be read coherently: arming on the even half freezes the odd half.
module slatch_rdbk
  import tom_rdbk_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int WAIT = 1
) (
  input  logic          sys_clk,
  input  logic          reset,
  slatch_rdbk_if.slave  bus
);

  localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT);

  state_t           state;
  logic [DW-1:0]    shadow;
  logic [DW-1:0]    pair_hold;
  logic             pair_valid;
  logic [AW-1:0]    pair_addr;
  logic [CNT_W-1:0] wait_cnt;

  // One extra address bit so that rd_addr+1 on the top index lands out of range, not on 0.
  logic [AW:0]   addr_cur;
  logic [AW:0]   addr_nxt;
  logic [DW-1:0] data_cur;
  logic [DW-1:0] data_nxt;
  logic          arm;
  logic          consume;
  logic [DW-1:0] cap_val;

  assign addr_cur = {1'b0, bus.rd_addr};
  assign addr_nxt = addr_cur + 1'b1;

  slatch_rdbk_sel #(.NREG(NREG), .DW(DW), .SW(AW + 1)) u_sel_cur (
    .regs_flat (bus.regs_flat),
    .sel       (addr_cur),
    .data      (data_cur)
  );

  slatch_rdbk_sel #(.NREG(NREG), .DW(DW), .SW(AW + 1)) u_sel_nxt (
    .regs_flat (bus.regs_flat),
    .sel       (addr_nxt),
    .data      (data_nxt)
  );

  // Pair decode for the request currently presented in IDLE.
  always_comb begin
    arm     = bus.rd_pair && !bus.rd_addr[0] && (int'(addr_cur) < NREG - 1);
    consume = pair_valid && (addr_cur == ({1'b0, pair_addr} + 1'b1));
    cap_val = consume ? pair_hold : data_cur;
  end

  // Read sequencer with registered bus outputs; busy spans acceptance through the drive cycle.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shadow      <= '0;
      pair_hold   <= '0;
      pair_valid  <= 1'b0;
      pair_addr   <= '0;
      wait_cnt    <= '0;
      bus.dout    <= '0;
      bus.dout_oe <= 1'b0;
      bus.rd_ack  <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      bus.dout    <= '0;
      bus.dout_oe <= 1'b0;
      bus.rd_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rd_req) begin
            shadow   <= cap_val;
            wait_cnt <= WAIT_C;
            bus.busy <= 1'b1;
            if (arm) begin
              pair_hold  <= data_nxt;
              pair_valid <= 1'b1;
              pair_addr  <= bus.rd_addr;
            end else begin
              pair_valid <= 1'b0;
            end
            if (WAIT == 0) begin
              state       <= DRIVE;
              bus.dout    <= cap_val;
              bus.dout_oe <= 1'b1;
              bus.rd_ack  <= 1'b1;
            end else begin
              state <= WAITST;
            end
          end
        end
        WAITST: begin
          if (wait_cnt == CNT_W'(1)) begin
            wait_cnt    <= '0;
            state       <= DRIVE;
            bus.dout    <= shadow;
            bus.dout_oe <= 1'b1;
            bus.rd_ack  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        DRIVE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
